// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment driver: segment bit positions,
// the hex glyph table (1 = lit, bit6 = a ... bit0 = g) and the blank glyph.
package sevenseg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to logical seven-segment glyph (1 = lit).
module hex7seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_TABLE[nibble_i];

endmodule

// File: rtl/mux_sevenseg_driver.sv
// Time-multiplexed seven-segment scanner with load-strobed shadow registers,
// optional leading-zero blanking and configurable pin polarity.
module mux_sevenseg_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_XOR  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    tick_q, tick_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [NUM_DIGITS-1:0]   an_log;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    blank_sel;
    logic                    run;
    logic [6:0]              seg_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            dpsh_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            seg_q   <= SEG_XOR;
            dp_q    <= DP_XOR;
            an_q    <= AN_XOR;
        end else begin
            value_q <= value_d;
            dpsh_q  <= dpsh_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    // Shadow capture and scan timing; load is independent of enable.
    always_comb begin
        value_d = load ? value : value_q;
        dpsh_d  = load ? dp_in : dpsh_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        if (enable) begin
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                presc_d = '0;
                if (idx_q == IW'(NUM_DIGITS - 1)) begin
                    idx_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // lead_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        run       = 1'b1;
        lead_zero = '0;
        an_log    = '0;
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run & (value_q[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                an_log[i] = 1'b1;
                nib_sel   = value_q[4*i +: 4];
                dp_sel    = dpsh_q[i];
                blank_sel = blank_lz && (i != 0) && lead_zero[i];
            end
        end
    end

    hex7seg_decode u_decode (
        .nibble_i (nib_sel),
        .seg_o    (seg_raw)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        an_d  = '0;
        if (enable) begin
            seg_d = blank_sel ? SEG_BLANK : seg_raw;
            dp_d  = dp_sel;
            an_d  = an_log;
        end
        seg_d = seg_d ^ SEG_XOR;
        dp_d  = dp_d ^ DP_XOR;
        an_d  = an_d ^ AN_XOR;
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_mux_sevenseg_driver.sv
// Directed bench: an active-high and an active-low instance share stimulus;
// outputs are sampled 1 time unit after each rising edge.
module tb_mux_sevenseg_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        ft_h, ft_l;

    int compared;
    int mismatched;

    mux_sevenseg_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h), .an(an_h),
        .frame_tick(ft_h)
    );

    mux_sevenseg_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_l), .dp(dp_l), .an(an_l),
        .frame_tick(ft_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset, load shadow with scanning off, then start scanning.
    // The next tick() after this is scan cycle 1 (digit 0, fresh period).
    task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic blz);
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        enable   = 1'b0;
        load     = 1'b1;
        value    = v;
        dp_in    = d;
        blank_lz = blz;
        tick();
        load     = 1'b0;
        enable   = 1'b1;
    endtask

    logic [6:0] exp_seg [4];
    logic [3:0] one;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        value      = 16'h0;
        dp_in      = 4'h0;
        blank_lz   = 1'b0;
        one        = 4'b0001;
        exp_seg    = '{7'h47, 7'h77, 7'h6D, 7'h30};

        #12;
        chk("rst_an",    {12'h0, an_h}, 16'h0000);
        chk("rst_seg",   {9'h0, seg_h}, 16'h0000);
        chk("rst_dp",    {15'h0, dp_h}, 16'h0000);
        chk("rst_ft",    {15'h0, ft_h}, 16'h0000);
        chk("rst_an_al", {12'h0, an_l}, 16'h000F);
        chk("rst_seg_al",{9'h0, seg_l}, 16'h007F);
        chk("rst_dp_al", {15'h0, dp_l}, 16'h0001);
        tick();

        // Full scan of 12AF, dp on digit 2, across one frame boundary.
        restart(16'h12AF, 4'b0100, 1'b0);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            int d;
            tick();
            d = ((cyc - 1) / 4) % 4;
            chk($sformatf("scan_an_c%0d", cyc),  {12'h0, an_h}, {12'h0, one << d});
            chk($sformatf("scan_seg_c%0d", cyc), {9'h0, seg_h}, {9'h0, exp_seg[d]});
            chk($sformatf("scan_dp_c%0d", cyc),  {15'h0, dp_h}, {15'h0, (d == 2)});
            chk($sformatf("scan_ft_c%0d", cyc),  {15'h0, ft_h}, {15'h0, (cyc == 16)});
            if (cyc <= 4) begin
                chk($sformatf("al_an_c%0d", cyc),  {12'h0, an_l}, 16'h000E);
                chk($sformatf("al_seg_c%0d", cyc), {9'h0, seg_l}, 16'h0038);
            end
        end

        // Leading-zero blanking on 0005, then blanking switched off live.
        restart(16'h0005, 4'b0000, 1'b1);
        for (int cyc = 1; cyc <= 32; cyc++) begin
            tick();
            if (cyc == 16) blank_lz = 1'b0;
            case (cyc)
                2:  chk("lz5_d0", {9'h0, seg_h}, 16'h005B);
                6:  chk("lz5_d1", {9'h0, seg_h}, 16'h0000);
                10: chk("lz5_d2", {9'h0, seg_h}, 16'h0000);
                14: chk("lz5_d3", {9'h0, seg_h}, 16'h0000);
                18: chk("nlz5_d0", {9'h0, seg_h}, 16'h005B);
                22: chk("nlz5_d1", {9'h0, seg_h}, 16'h007E);
                26: chk("nlz5_d2", {9'h0, seg_h}, 16'h007E);
                30: chk("nlz5_d3", {9'h0, seg_h}, 16'h007E);
                default: ;
            endcase
            if (cyc == 14) chk("lz5_an_d3", {12'h0, an_h}, 16'h0008);
        end

        restart(16'h0000, 4'b0000, 1'b1);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            case (cyc)
                2:  chk("lz0_d0", {9'h0, seg_h}, 16'h007E);
                6:  chk("lz0_d1", {9'h0, seg_h}, 16'h0000);
                10: chk("lz0_d2", {9'h0, seg_h}, 16'h0000);
                14: chk("lz0_d3", {9'h0, seg_h}, 16'h0000);
                default: ;
            endcase
        end

        restart(16'h0100, 4'b0000, 1'b1);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            case (cyc)
                2:  chk("lz100_d0", {9'h0, seg_h}, 16'h007E);
                6:  chk("lz100_d1", {9'h0, seg_h}, 16'h007E);
                10: chk("lz100_d2", {9'h0, seg_h}, 16'h0030);
                14: chk("lz100_d3", {9'h0, seg_h}, 16'h0000);
                default: ;
            endcase
        end

        // Active-low pins with an 8 on digit 0, then enable dropped.
        restart(16'h0008, 4'b0000, 1'b0);
        tick();
        tick();
        chk("al8_an",  {12'h0, an_l}, 16'h000E);
        chk("al8_seg", {9'h0, seg_l}, 16'h0000);
        chk("al8_dp",  {15'h0, dp_l}, 16'h0001);
        chk("ah8_seg", {9'h0, seg_h}, 16'h007F);
        enable = 1'b0;
        tick();
        chk("aloff_an",  {12'h0, an_l}, 16'h000F);
        chk("aloff_seg", {9'h0, seg_l}, 16'h007F);
        chk("aloff_dp",  {15'h0, dp_l}, 16'h0001);
        chk("ahoff_an",  {12'h0, an_h}, 16'h0000);
        chk("ahoff_seg", {9'h0, seg_h}, 16'h0000);

        // Pause mid-digit-2 for 10 cycles; scan resumes with remaining count.
        restart(16'h12AF, 4'b0100, 1'b0);
        for (int cyc = 1; cyc <= 10; cyc++) tick();
        chk("pause_pre_an", {12'h0, an_h}, 16'h0004);
        enable = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            chk($sformatf("pause_an_%0d", cyc), {12'h0, an_h}, 16'h0000);
            chk($sformatf("pause_ft_%0d", cyc), {15'h0, ft_h}, 16'h0000);
        end
        enable = 1'b1;
        tick();
        chk("resume1_an",  {12'h0, an_h}, 16'h0004);
        chk("resume1_seg", {9'h0, seg_h}, 16'h006D);
        chk("resume1_dp",  {15'h0, dp_h}, 16'h0001);
        tick();
        chk("resume2_an",  {12'h0, an_h}, 16'h0004);
        tick();
        chk("resume3_an",  {12'h0, an_h}, 16'h0008);
        chk("resume3_seg", {9'h0, seg_h}, 16'h0030);
        tick();
        tick();

        // Asynchronous reset between edges, then restart from digit 0.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an",    {12'h0, an_h}, 16'h0000);
        chk("arst_seg",   {9'h0, seg_h}, 16'h0000);
        chk("arst_dp",    {15'h0, dp_h}, 16'h0000);
        chk("arst_an_al", {12'h0, an_l}, 16'h000F);
        chk("arst_seg_al",{9'h0, seg_l}, 16'h007F);
        #1;
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            if (cyc <= 4) begin
                chk($sformatf("post_an_c%0d", cyc),  {12'h0, an_h}, 16'h0001);
                chk($sformatf("post_seg_c%0d", cyc), {9'h0, seg_h}, 16'h007E);
                chk($sformatf("post_dp_c%0d", cyc),  {15'h0, dp_h}, 16'h0000);
            end else begin
                chk("post_an_c5",  {12'h0, an_h}, 16'h0002);
                chk("post_seg_c5", {9'h0, seg_h}, 16'h007E);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_sevenseg_driver.md
Name: mux_sevenseg_driver

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus. It latches a packed hex value and per-digit decimal points on a load strobe, then scans the digits at a programmable refresh rate. It also provides optional leading-zero blanking and selectable output polarity. It sits between the datapath result registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16); digit 0 is rightmost, value[3:0].
REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2).
SEG_ACTIVE_LOW, 0, 1 = seg/dp pins driven low to light a segment.
AN_ACTIVE_LOW, 0, 1 = an pins driven low to select a digit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan; 0 = all digits off, counters hold
load  in  1  capture value/dp_in into shadow registers
value  in  4*NUM_DIGITS  packed hex nibbles, digit i = value[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_lz  in  1  1 = suppress leading zeros (sampled continuously)
seg  out  7  segments, bit6=a ... bit0=g, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point of the selected digit
an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (rst_n low, async): shadow value/dp = 0; prescaler = 0; digit index = 0; an all inactive; seg and dp inactive; frame_tick = 0.
- Reset is honoured mid-scan; scanning restarts at digit 0 with a full REFRESH_DIV period.
- Load: when load=1 at a rising edge, the shadow registers take value/dp_in. Outputs reflect new data on the following edge, i.e. 1-cycle latency. load works regardless of enable.
- Prescaler: counts 0..REFRESH_DIV-1 while enable=1, then wraps to 0 and advances the index.
- Index sequence: 0,1,...,NUM_DIGITS-1,0. On the wrap to 0, frame_tick=1 for exactly that cycle. For NUM_DIGITS=1 the index stays at 0, and frame_tick pulses once every REFRESH_DIV cycles.
- Outputs are registered. Each cycle, seg/dp/an are computed from the current index and shadow, so they lag an index change by 1 cycle.
- an: bit[index] active, others inactive; when enable=0, all inactive. Seg and dp are inactive, and prescaler/index hold their values.
- Hex decode, logical with 1 = lit, bit6..0 = a..g:
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
  - 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
- Leading-zero blanking: when blank_lz=1, digit i>0 is blanked (seg inactive) if shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. dp still follows the shadow dp even on blanked digits.
- Polarity: the final seg/dp are inverted if SEG_ACTIVE_LOW, and an is inverted if AN_ACTIVE_LOW. Inactive level = logical 0 before inversion.
- Simultaneous load and index advance: the new shadow and new index both apply at the same output update (no mixing of old and new data).
- Prescaler width = clog2(REFRESH_DIV); index width = max(1, clog2(NUM_DIGITS)).

Decomposition:
- Package sevenseg_pkg holds:
  - segment bit-position constants (SEG_A=6..SEG_G=0);
  - the 16-entry hex-to-segment constant table;
  - a blank pattern constant 7'b0000000.
- One combinational sub-module, hex7seg_decode (4-bit nibble in, 7-bit logical segments out, table from the package), instantiated once after the digit mux.

Test Plan:
- Reset, then NUM_DIGITS=4, REFRESH_DIV=4, load value=16'h12AF, dp_in=4'b0100, enable=1 -> an cycles 0001,0010,0100,1000 every 4 clocks. seg cycles 47,77,6D,30. dp=1 only while an=0100. frame_tick pulses on each return to 0001.
- load 16'h0005 with blank_lz=1 -> digits 3..1 seg=00, digit 0 seg=5B. With blank_lz=0 -> digits 3..1 show 7E.
- load 16'h0000 with blank_lz=1 -> only digit 0 lit (7E); loading 16'h0100 lights digits 2..0 (30,7E,7E), digit 3 blank.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, value digit 0 = 8 -> seg=7'h00 and an=4'b1110 while digit 0 is selected. When enable=0 -> an=4'b1111, seg=7F, dp=1.
- Drop enable for 10 cycles mid-digit-2, then raise it -> the scan resumes on digit 2 with the remaining prescaler count; no frame_tick while disabled.
- Assert rst_n low mid-frame asynchronously (between clock edges) -> outputs go inactive immediately. After release, the first selected digit is 0, the shadow is 0, and seg shows 7E (blank_lz=0) after 1 cycle.
